u_lsu_ctrl: RTL

Load/store sequencer between the execute stage and the single data SRAM port (1-cycle read latency, per-byte lanes).
- Accepts one request at a time and drives SRAM address, lanes and write data.
- For loads, collects read data, then aligns and sign/zero-extends it and writes it back to the register file.
- Holds execute off via req_ready while busy.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/u_lsu_ctrl_align.sv | 41 ++++
 rtl/u_lsu_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store sequencer.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_B0   = 2'd1,
    S_B1   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Unsigned forms exist only for byte/half loads.
  function automatic logic f3_legal(input logic st, input logic [2:0] f3);
    if (st)
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/u_lsu_ctrl_align.sv
// Combinational lane math: byte-lane mask, shifted store data, aligned and extended load result.
module u_lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wd,
  input  logic [63:0] rdata,
  output logic [7:0]  mask,
  output logic [63:0] wdata,
  output logic [31:0] result
);

  logic [3:0]  bmask;
  logic [31:0] sh_lo;

  function automatic logic [31:0] ext_load(input logic [31:0] d, input logic [1:0] sz,
                                           input logic u);
    logic [31:0] r;
    case (sz)
      SZ_B:    r = u ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      SZ_H:    r = u ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    case (size)
      SZ_B:    bmask = 4'h1;
      SZ_H:    bmask = 4'h3;
      default: bmask = 4'hF;
    endcase
    mask   = {4'h0, bmask} << off;
    wdata  = {32'h0, wd} << {off, 3'b000};
    sh_lo  = 32'(rdata >> {off, 3'b000});
    result = ext_load(sh_lo, size, uns);
  end

endmodule

// File: rtl/u_lsu_ctrl.sv
// Load/store sequencer onto a single 1-cycle-latency byte-laned SRAM port.
// Define LSU_MISALIGN_EN to split word-crossing accesses into two beats; otherwise they fault.
module u_lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_v,
  output logic          req_ready,
  input  logic          req_st,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wd,
  input  logic [4:0]    req_rd_a,
  output logic          done,
  output logic          err,
  output logic          rd_e,
  output logic [4:0]    rd_a,
  output logic [31:0]   rd_d,
  output logic [AW-1:0] dat_a,
  output logic [3:0]    dat_we,
  output logic [31:0]   dat_wd,
  output logic [3:0]    dat_re,
  input  logic [31:0]   dat_rd
);

`ifdef LSU_MISALIGN_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  state_e          state, nxt;
  logic            st_p0;
  logic [2:0]      f3_p0;
  logic [AW+1:0]   addr_p0;
  logic [31:0]     wd_p0;
  logic [4:0]      rd_a_p0;
  logic [31:0]     beat0_p1;

  logic [7:0]      mask;
  logic [63:0]     wdata;
  logic [63:0]     rdata;
  logic [31:0]     result;
  logic [AW-1:0]   w0, w1;
  logic            split, bad;
  logic            unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];

  assign w0    = addr_p0[AW+1:2];
  assign w1    = w0 + AW'(1);
  assign split = |mask[7:4];
  assign bad   = !f3_legal(st_p0, f3_p0) || (split && !MISALIGN_EN);
  assign rdata = split ? {dat_rd, beat0_p1} : {32'h0, dat_rd};

  u_lsu_align u_align (
    .off    (addr_p0[1:0]),
    .size   (f3_p0[1:0]),
    .uns    (f3_p0[2]),
    .wd     (wd_p0),
    .rdata  (rdata),
    .mask   (mask),
    .wdata  (wdata),
    .result (result)
  );

  // Request latch stage (p0) and beat-0 capture (p1)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      st_p0    <= 1'b0;
      f3_p0    <= 3'b000;
      addr_p0  <= '0;
      wd_p0    <= 32'h0;
      rd_a_p0  <= 5'd0;
      beat0_p1 <= 32'h0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && req_v) begin
        st_p0   <= req_st;
        f3_p0   <= req_funct3;
        addr_p0 <= req_addr[AW+1:0];
        wd_p0   <= req_wd;
        rd_a_p0 <= req_rd_a;
      end
      if (state == S_B1)
        beat0_p1 <= dat_rd;
    end
  end

  always_comb begin
    nxt       = state;
    req_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    rd_e      = 1'b0;
    rd_a      = 5'd0;
    rd_d      = 32'h0;
    dat_a     = '0;
    dat_we    = 4'h0;
    dat_re    = 4'h0;
    dat_wd    = 32'h0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_v)
          nxt = S_B0;
      end
      S_B0: begin
        dat_a = w0;
        if (!bad) begin
          if (st_p0) begin
            dat_we = mask[3:0];
            dat_wd = wdata[31:0];
          end else begin
            dat_re = mask[3:0];
          end
        end
        nxt = (!bad && split) ? S_B1 : S_RESP;
      end
      S_B1: begin
        dat_a = w1;
        if (st_p0) begin
          dat_we = mask[7:4];
          dat_wd = wdata[63:32];
        end else begin
          dat_re = mask[7:4];
        end
        nxt = S_RESP;
      end
      S_RESP: begin
        done = 1'b1;
        err  = bad;
        // x0 is filtered by the register file, so rd_e is not gated on rd_a.
        if (!st_p0 && !bad) begin
          rd_e = 1'b1;
          rd_a = rd_a_p0;
          rd_d = result;
        end
        nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule
